life_sequencer: RTL and testbench
=================================

LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- X, 8, board width in cells.
- Y, 8, board height in cells.
- LOG2X, 3, bits for the X index.
- LOG2Y, 3, bits for the Y index.
- SPEED_BITS, 8, width of the generation-period setting.
- GEN_BITS, 16, width of the generation counter.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- run_key, input, 1, single-cycle pulse that toggles run/pause.
- step_key, input, 1, single-cycle pulse that requests one generation while paused.
- tick, input, 1, single-cycle timebase strobe for the period timer.
- speed, input, SPEED_BITS, number of ticks to wait between generations; 0 means back-to-back.
- cnt, output, LOG2X+LOG2Y, cell index driven to the datapath and row scanner.
- nxt_bit, output, 1, datapath shift enable; high for each cell computed.
- running, output, 1, high in run mode.
- busy, output, 1, high while a generation is being computed.
- gen_done, output, 1, one-cycle pulse at the end of each generation.
- gen_count, output, GEN_BITS, count of completed generations.

Function
REQ-003 The block SHALL have three states: PAUSE, WAIT and CALC. The state SHALL be registered. The encoding is free.
REQ-004 cnt SHALL increment by 1 every clock in every state and SHALL wrap from X*Y-1 to 0. It SHALL never hold and never skip a value.
REQ-005 nxt_bit SHALL be 1 exactly when the state is CALC, and 0 otherwise.
REQ-006 CALC SHALL be entered only on the clock where cnt goes from X*Y-1 to 0. CALC SHALL last exactly X*Y cycles, with cnt taking the values 0..X*Y-1 in order.
REQ-007 PAUSE behaviour:
- A step_key pulse sets the step_pend flag.
- When step_pend=1 and cnt=X*Y-1, the next state SHALL be CALC and step_pend SHALL clear.
REQ-008 PAUSE with a run_key pulse: running SHALL go to 1, the period timer SHALL load speed, and the next state SHALL be WAIT.
REQ-009 WAIT behaviour:
- Each tick with timer>0 decrements the timer by 1.
- When timer=0 and cnt=X*Y-1, the next state SHALL be CALC.
- A run_key pulse in WAIT SHALL clear running and return the block to PAUSE on the next clock.
REQ-010 On the last CALC cycle (cnt=X*Y-1):
- gen_done SHALL pulse for that one cycle.
- gen_count SHALL increment, wrapping modulo 2^GEN_BITS.
- The next state SHALL be WAIT (with the timer reloaded from speed) if running=1, otherwise PAUSE.
REQ-011 A run_key pulse during CALC SHALL toggle running immediately. A generation SHALL never be aborted; the new mode takes effect at the REQ-010 exit.
REQ-012 step_key SHALL be ignored while running=1 and while in CALC. step_pend SHALL NOT be set in those cases.
REQ-013 If run_key and step_key pulse in the same cycle, run_key SHALL take effect and step_key SHALL be discarded.
REQ-014 speed SHALL be sampled only when the timer loads. Changes to speed while waiting SHALL NOT affect the period in progress.
REQ-015 With speed=0 in run mode, CALC periods SHALL repeat with exactly X*Y non-CALC cycles between them, since the WAIT exit is at the cnt wrap.
REQ-016 busy SHALL equal nxt_bit. All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-017 While reset=1 on a clock edge, the following SHALL be 0 on the next cycle: state=PAUSE, cnt, nxt_bit, running, busy, gen_done, gen_count, step_pend, timer.
REQ-018 A reset asserted mid-CALC SHALL abandon the generation with no gen_done pulse and no gen_count increment.

Verification (X=Y=8)
REQ-019 Reset, then idle 200 clocks: cnt cycles 0..63 repeatedly; nxt_bit, gen_done and gen_count stay 0.
REQ-020 step_key pulsed at cnt=10: nxt_bit is high for 64 cycles starting at the next cnt=0; gen_done pulses at cnt=63; gen_count=1; state returns to PAUSE.
REQ-021 speed=3, run_key, 3 ticks issued early: CALC starts at the first cnt wrap after the timer reaches 0; gen_count increments once per period; running=1.
REQ-022 run_key pulsed at cnt=20 during CALC: the generation completes (64 nxt_bit cycles), gen_done pulses, and the block returns to PAUSE with running=0.
REQ-023 run_key and step_key in the same cycle while paused: running=1; no CALC occurs before the timer expires.
REQ-024 reset asserted at cnt=30 during CALC: the next cycle shows cnt=0, nxt_bit=0, gen_count unchanged (0), and no gen_done pulse.

Source files
------------

// File: rtl/life_sequencer_if.sv
// Control/status bundle between the Life sequencer and its surroundings.
// The slave modport is the sequencer side.
interface life_sequencer_if #(
    parameter int LOG2X      = 3,
    parameter int LOG2Y      = 3,
    parameter int SPEED_BITS = 8,
    parameter int GEN_BITS   = 16
);
    logic                   run_key;
    logic                   step_key;
    logic                   tick;
    logic [SPEED_BITS-1:0]  speed;
    logic [LOG2X+LOG2Y-1:0] cnt;
    logic                   nxt_bit;
    logic                   running;
    logic                   busy;
    logic                   gen_done;
    logic [GEN_BITS-1:0]    gen_count;

    modport master (
        output run_key, step_key, tick, speed,
        input  cnt, nxt_bit, running, busy, gen_done, gen_count
    );

    modport slave (
        input  run_key, step_key, tick, speed,
        output cnt, nxt_bit, running, busy, gen_done, gen_count
    );
endinterface

// File: rtl/life_sequencer.sv
// Generation sequencer for a Game of Life board: free-running cell scan,
// run/pause/single-step control and a tick-based generation period.
module life_sequencer #(
    parameter int X          = 8,
    parameter int Y          = 8,
    parameter int LOG2X      = 3,
    parameter int LOG2Y      = 3,
    parameter int SPEED_BITS = 8,
    parameter int GEN_BITS   = 16
) (
    input  logic             clk,
    input  logic             reset,
    life_sequencer_if.slave  io
);
    localparam int CW = LOG2X + LOG2Y;
    localparam logic [CW-1:0] LAST = CW'(X * Y - 1);

    typedef enum logic [1:0] {
        PAUSE,
        WAIT,
        CALC
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_running;
    logic                  r_step_pend;
    logic [SPEED_BITS-1:0] r_timer;
    logic [GEN_BITS-1:0]   r_gen_count;

    state_t                w_state_nxt;
    logic                  w_running_nxt;
    logic                  w_step_nxt;
    logic [SPEED_BITS-1:0] w_timer_nxt;
    logic [GEN_BITS-1:0]   w_gen_nxt;
    logic                  w_last;

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_running_nxt = r_running;
        w_step_nxt    = r_step_pend;
        w_timer_nxt   = r_timer;
        w_gen_nxt     = r_gen_count;
        unique case (r_state)
            PAUSE: begin
                // run_key wins over a simultaneous step_key
                if (io.run_key) begin
                    w_running_nxt = 1'b1;
                    w_timer_nxt   = io.speed;
                    w_step_nxt    = 1'b0;
                    w_state_nxt   = WAIT;
                end else if (r_step_pend && w_last) begin
                    w_step_nxt  = 1'b0;
                    w_state_nxt = CALC;
                end else if (io.step_key) begin
                    w_step_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (io.run_key) begin
                    w_running_nxt = 1'b0;
                    w_state_nxt   = PAUSE;
                end else if (r_timer == '0) begin
                    if (w_last) w_state_nxt = CALC;
                end else if (io.tick) begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            CALC: begin
                if (io.run_key) w_running_nxt = ~r_running;
                // a generation always runs to completion
                if (w_last) begin
                    w_gen_nxt = r_gen_count + 1'b1;
                    if (w_running_nxt) begin
                        w_timer_nxt = io.speed;
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = PAUSE;
                    end
                end
            end
            default: w_state_nxt = PAUSE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= PAUSE;
            r_cnt       <= '0;
            r_running   <= 1'b0;
            r_step_pend <= 1'b0;
            r_timer     <= '0;
            r_gen_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
            r_running   <= w_running_nxt;
            r_step_pend <= w_step_nxt;
            r_timer     <= w_timer_nxt;
            r_gen_count <= w_gen_nxt;
        end
    end

    assign io.cnt       = r_cnt;
    assign io.nxt_bit   = (r_state == CALC);
    assign io.busy      = (r_state == CALC);
    assign io.running   = r_running;
    assign io.gen_done  = (r_state == CALC) && w_last;
    assign io.gen_count = r_gen_count;
endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer on an 8x8 board: vector table,
// directed corner sequences and randomized traffic against a reference model.
module tb_life_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    life_sequencer_if io ();

    life_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    // Reference model: the board scan is a mod-64 counter, the mode is one of
    // idle / waiting / computing, and a generation ends on the scan wrap.
    localparam int IDLE = 0;
    localparam int WAITING = 1;
    localparam int COMPUTING = 2;
    int m_cnt = 0;
    int m_mode = IDLE;
    int m_timer = 0;
    int m_gen = 0;
    bit m_run = 0;
    bit m_pend = 0;

    task automatic model_step(input bit rst, r, s, t, input int spd);
        bit wrap;
        wrap = (m_cnt == 63);
        if (rst) begin
            m_cnt = 0; m_mode = IDLE; m_timer = 0;
            m_gen = 0; m_run = 0; m_pend = 0;
            return;
        end
        if (m_mode == COMPUTING) begin
            if (r) m_run = !m_run;
            if (wrap) begin
                m_gen = (m_gen + 1) % 65536;
                m_mode = m_run ? WAITING : IDLE;
                if (m_run) m_timer = spd;
            end
        end else if (m_mode == WAITING) begin
            if (r) begin
                m_run = 0;
                m_mode = IDLE;
            end else if (m_timer == 0) begin
                if (wrap) m_mode = COMPUTING;
            end else if (t) begin
                m_timer = m_timer - 1;
            end
        end else begin
            if (r) begin
                m_run = 1; m_timer = spd; m_pend = 0;
                m_mode = WAITING;
            end else if (m_pend && wrap) begin
                m_pend = 0;
                m_mode = COMPUTING;
            end else if (s) begin
                m_pend = 1;
            end
        end
        m_cnt = (m_cnt + 1) % 64;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, edge, return at next negedge with pulses low.
    task automatic clk1(input bit rst, r, s, t);
        reset = rst;
        io.run_key = r;
        io.step_key = s;
        io.tick = t;
        @(posedge clk);
        model_step(rst, r, s, t, int'(io.speed));
        @(negedge clk);
        reset = 1'b0;
        io.run_key = 1'b0;
        io.step_key = 1'b0;
        io.tick = 1'b0;
    endtask

    task automatic idle_to(input int c);
        int k;
        k = 0;
        while (int'(io.cnt) != c && k < 200) begin
            clk1(0, 0, 0, 0);
            k++;
        end
        chk("reach_cnt", io.cnt, c);
    endtask

    typedef struct {
        bit       rst, run, step, tk;
        bit [7:0] spd;
        int       e_cnt;
        bit       e_nxt, e_run, e_gd;
        int       e_gc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int nn, gd, first, gdcnt, k, wt;
        bit r, pulsed;
        io.run_key = 0; io.step_key = 0; io.tick = 0; io.speed = '0;

        tbl[0] = '{1, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 8'd0, 2, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 8'd5, 3, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 8'd5, 4, 0, 1, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 8'd5, 5, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 1, 0, 8'd5, 6, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 1, 0, 8'd5, 7, 0, 1, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 8'd5, 8, 0, 1, 0, 0};
        tbl[9] = '{0, 1, 0, 0, 8'd5, 9, 0, 0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            io.speed = tbl[i].spd;
            clk1(tbl[i].rst, tbl[i].run, tbl[i].step, tbl[i].tk);
            chk($sformatf("tbl%0d_cnt", i), io.cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_nxt", i), io.nxt_bit, tbl[i].e_nxt);
            chk($sformatf("tbl%0d_run", i), io.running, tbl[i].e_run);
            chk($sformatf("tbl%0d_gd", i), io.gen_done, tbl[i].e_gd);
            chk($sformatf("tbl%0d_gc", i), io.gen_count, tbl[i].e_gc);
        end

        // Reset state, then 200 idle clocks
        clk1(1, 0, 0, 0);
        chk("rst_cnt", io.cnt, 0);
        chk("rst_nxt", io.nxt_bit, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_run", io.running, 0);
        chk("rst_gd", io.gen_done, 0);
        chk("rst_gc", io.gen_count, 0);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            clk1(0, 0, 0, 0);
            if (int'(io.cnt) != i % 64 || io.nxt_bit || io.gen_done
                || io.gen_count != 0) k++;
        end
        chk("idle200_bad", k, 0);
        chk("idle200_cnt", io.cnt, 8);

        // Single step requested at cnt=10
        idle_to(10);
        clk1(0, 0, 1, 0);
        nn = 0; gd = 0; first = -1; gdcnt = -1;
        for (int i = 0; i < 200; i++) begin
            if (io.nxt_bit) begin
                if (first < 0) first = io.cnt;
                nn++;
            end
            if (io.gen_done) begin gd++; gdcnt = io.cnt; end
            clk1(0, 0, 0, 0);
        end
        chk("step_first_cnt", first, 0);
        chk("step_nxt_len", nn, 64);
        chk("step_gd_cnt", gd, 1);
        chk("step_gd_at", gdcnt, 63);
        chk("step_gc", io.gen_count, 1);
        chk("step_running", io.running, 0);

        // Run mode with speed=3 and three early ticks
        clk1(1, 0, 0, 0);
        io.speed = 8'd3;
        idle_to(5);
        clk1(0, 1, 0, 0);
        chk("run_on", io.running, 1);
        for (int i = 0; i < 3; i++) clk1(0, 0, 0, 1);
        nn = 0; wt = -1;
        for (int i = 0; i < 300; i++) begin
            if (io.nxt_bit) begin
                if (wt < 0) wt = i;
                nn++;
            end
            clk1(0, 0, 0, 0);
        end
        chk("run_calc_wait", wt, 55);
        chk("run_nxt_len", nn, 64);
        chk("run_gc1", io.gen_count, 1);
        chk("run_still", io.running, 1);
        for (int i = 0; i < 3; i++) clk1(0, 0, 0, 1);
        nn = 0;
        for (int i = 0; i < 200; i++) begin
            if (io.nxt_bit) nn++;
            clk1(0, 0, 0, 0);
        end
        chk("run2_nxt_len", nn, 64);
        chk("run_gc2", io.gen_count, 2);

        // run_key at cnt=20 mid-generation: finish it, then pause
        clk1(1, 0, 0, 0);
        io.speed = 8'd0;
        clk1(0, 1, 0, 0);
        nn = 0; gd = 0; pulsed = 0;
        for (int i = 0; i < 300; i++) begin
            r = 0;
            if (io.nxt_bit) nn++;
            if (io.gen_done) gd++;
            if (io.nxt_bit && io.cnt == 20 && !pulsed) begin
                r = 1;
                pulsed = 1;
            end
            clk1(0, r, 0, 0);
            if (r) begin
                chk("calc_run_toggle", io.running, 0);
                chk("calc_no_abort", io.nxt_bit, 1);
            end
        end
        chk("calc_pulsed", pulsed, 1);
        chk("calc_nxt_len", nn, 64);
        chk("calc_gd", gd, 1);
        chk("calc_run_end", io.running, 0);
        chk("calc_gc", io.gen_count, 1);

        // run_key together with step_key while paused
        clk1(1, 0, 0, 0);
        io.speed = 8'd2;
        idle_to(40);
        clk1(0, 1, 1, 0);
        chk("both_run", io.running, 1);
        nn = 0;
        for (int i = 0; i < 200; i++) begin
            if (io.nxt_bit) nn++;
            clk1(0, 0, 0, 0);
        end
        chk("both_no_calc", nn, 0);
        clk1(0, 0, 0, 1);
        clk1(0, 0, 0, 1);
        nn = 0;
        for (int i = 0; i < 200; i++) begin
            if (io.nxt_bit) nn++;
            clk1(0, 0, 0, 0);
        end
        chk("both_calc_len", nn, 64);
        chk("both_gc", io.gen_count, 1);

        // Reset at cnt=30 during CALC
        clk1(1, 0, 0, 0);
        idle_to(5);
        clk1(0, 0, 1, 0);
        k = 0;
        while (!(io.nxt_bit && io.cnt == 30) && k < 200) begin
            clk1(0, 0, 0, 0);
            k++;
        end
        chk("rstcalc_reach", io.nxt_bit && io.cnt == 30, 1);
        clk1(1, 0, 0, 0);
        chk("rstcalc_cnt", io.cnt, 0);
        chk("rstcalc_nxt", io.nxt_bit, 0);
        chk("rstcalc_gc", io.gen_count, 0);
        chk("rstcalc_gd", io.gen_done, 0);
        nn = 0; gd = 0;
        for (int i = 0; i < 100; i++) begin
            clk1(0, 0, 0, 0);
            if (io.nxt_bit) nn++;
            if (io.gen_done) gd++;
        end
        chk("rstcalc_after_nxt", nn, 0);
        chk("rstcalc_after_gd", gd, 0);
        chk("rstcalc_after_gc", io.gen_count, 0);

        // Randomized traffic against the model
        clk1(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            chk("rnd_cnt", io.cnt, m_cnt);
            chk("rnd_nxt", io.nxt_bit, m_mode == COMPUTING);
            chk("rnd_busy", io.busy, m_mode == COMPUTING);
            chk("rnd_run", io.running, m_run);
            chk("rnd_gd", io.gen_done,
                m_mode == COMPUTING && m_cnt == 63);
            chk("rnd_gc", io.gen_count, m_gen);
            if ($urandom_range(0, 99) == 0)
                io.speed = 8'($urandom_range(0, 4));
            clk1($urandom_range(0, 1999) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
